bcd_disp_scan: RTL

//  Multiplexed 7-segment display scanner for the stopwatch. Reads the BCD digit

---
 rtl/bcd_disp_scan.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bcd_disp_scan.sv
// Multiplexed 7-segment scanner: latches a tear-free BCD snapshot once per frame
// and drives one digit at a time with decode, decimal points and leading-zero blanking.
module bcd_disp_scan #(
    parameter int              NDIG     = 6,
    parameter int              SCAN_DIV = 1000,
    parameter logic [NDIG-1:0] DP_MASK  = 6'b010100,
    parameter int              LZB_MIN  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              HOLD,
    input  logic [4*NDIG-1:0] DIN,
    output logic [6:0]        SEG,
    output logic              DP,
    output logic [NDIG-1:0]   AN,
    output logic              FRAME
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] snap_q, snap_d;
    logic              fresh_q, fresh_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [NDIG-1:0]   an_q, an_d;

    logic       tick;
    logic       last_digit;
    logic       slot;
    logic       blank;
    logic [3:0] cur_digit;
    logic [6:0] cur_seg;
    logic [3:0] digit [NDIG];
    logic [NDIG:0] zero_above;

    // zero_above[i] is set when snapshot digit i and every digit above it are zero.
    assign zero_above[NDIG] = 1'b1;
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign digit[gi]      = snap_q[4*gi +: 4];
        assign zero_above[gi] = zero_above[gi+1] && (digit[gi] == 4'd0);
    end

    assign tick       = EN && (pre_q == PW'(SCAN_DIV - 1));
    assign last_digit = (idx_q == IW'(NDIG - 1));
    assign slot       = (fresh_q && EN) || (tick && last_digit);
    assign cur_digit  = digit[idx_q];
    assign blank      = (int'(idx_q) >= LZB_MIN) && zero_above[idx_q];

    always_comb begin
        case (cur_digit)
            4'd0:    cur_seg = 7'h3F;
            4'd1:    cur_seg = 7'h06;
            4'd2:    cur_seg = 7'h5B;
            4'd3:    cur_seg = 7'h4F;
            4'd4:    cur_seg = 7'h66;
            4'd5:    cur_seg = 7'h6D;
            4'd6:    cur_seg = 7'h7D;
            4'd7:    cur_seg = 7'h07;
            4'd8:    cur_seg = 7'h7F;
            4'd9:    cur_seg = 7'h6F;
            default: cur_seg = 7'h40;
        endcase
    end

    always_comb begin
        pre_d   = pre_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        fresh_d = fresh_q;
        seg_d   = 7'h00;
        dp_d    = 1'b0;
        an_d    = '0;
        if (EN) begin
            if (tick) begin
                pre_d = '0;
                idx_d = last_digit ? '0 : idx_q + IW'(1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
            an_d = NDIG'(1) << idx_q;
            if (!blank) begin
                seg_d = cur_seg;
                dp_d  = DP_MASK[idx_q];
            end
        end
        // HOLD only suppresses the load; the slot itself (and FRAME) still happens.
        if (slot) begin
            fresh_d = 1'b0;
            if (!HOLD) begin
                snap_d = DIN;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            fresh_q <= 1'b1;
            seg_q   <= 7'h00;
            dp_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            fresh_q <= fresh_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign AN    = an_q;
    assign FRAME = slot;
endmodule
